// File: rtl/shift_pkg.sv
// shift_pkg: shared enums for the multi-cycle shifter
//   op_e    : shift mode encoding (SRL=00, SRA=01, SLL=10, ROR=11)
//   state_e : controller states (IDLE, SHIFT, DONE)
package shift_pkg;

   typedef enum logic [1:0] {
      SRL = 2'b00,
      SRA = 2'b01,
      SLL = 2'b10,
      ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of one word by k (0..STEP) bits in a given mode
//   i_data : operand
//   i_k    : shift amount for this step
//   i_op   : shift mode
//   o_data : shifted result
module shift_step
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [KW-1:0]    i_k,
   input  op_e              i_op,
   output logic [WIDTH-1:0] o_data
);

   logic signed [WIDTH-1:0] w_sra;
   logic        [WIDTH-1:0] w_ror;

   // kept in its own signed net so the arithmetic shift is not turned logical
   // by mixing with unsigned operands in the mode select below
   assign w_sra = $signed(i_data) >>> i_k;
   // rotating a doubled word right leaves the rotated value in the low half
   assign w_ror = WIDTH'({i_data, i_data} >> i_k);

   always_comb
      o_data = (i_op == SRL) ? i_data >> i_k :
               (i_op == SRA) ? w_sra :
               (i_op == SLL) ? i_data << i_k : w_ror;

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shifter, up to STEP bits per cycle, valid/ready in and out
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake (in_ready high only in IDLE)
//   din, shamt, op      : operand, shift amount, mode (sampled at handshake)
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   dout                : result / working register
//   busy                : high in SHIFT or DONE
module shift_seq
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int STEP  = 1,
   localparam int SHW   = $clog2(WIDTH),
   localparam int KW    = $clog2(STEP + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             busy
);

   state_e           r_state;
   op_e              r_op;
   logic [SHW-1:0]   r_rem;
   logic [WIDTH-1:0] r_dout;
   logic [SHW-1:0]   w_k;
   logic [WIDTH-1:0] w_step;

   // k = min(STEP, remaining); when STEP covers the whole word, remaining always fits
   assign w_k = (STEP < WIDTH && r_rem > SHW'(STEP)) ? SHW'(STEP) : r_rem;

   shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .i_data (r_dout),
      .i_k    (KW'(w_k)),
      .i_op   (r_op),
      .o_data (w_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_op    <= SRL;
         r_rem   <= '0;
         r_dout  <= '0;
      end else begin
         case (r_state)
            IDLE:
               if (in_valid) begin
                  r_dout  <= din;
                  r_op    <= op_e'(op);
                  r_rem   <= shamt;
                  r_state <= (shamt != '0) ? SHIFT : DONE;
               end
            SHIFT: begin
               r_dout <= w_step;
               r_rem  <= r_rem - w_k;
               if (r_rem == w_k)
                  r_state <= DONE;
            end
            DONE:
               if (out_ready)
                  r_state <= IDLE;
            default:
               r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == SHIFT) || (r_state == DONE);
   assign dout      = r_dout;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed self-checking bench for shift_seq in three configurations
module tb_shift_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   // config a: WIDTH=8 STEP=1
   logic       a_iv = 0, a_ir, a_ov, a_or = 0, a_busy;
   logic [7:0] a_din = 0, a_dout;
   logic [2:0] a_sh = 0;
   logic [1:0] a_op = 0;
   // config b: WIDTH=8 STEP=4
   logic       b_iv = 0, b_ir, b_ov, b_or = 0, b_busy;
   logic [7:0] b_din = 0, b_dout;
   logic [2:0] b_sh = 0;
   logic [1:0] b_op = 0;
   // config c: WIDTH=32 STEP=8
   logic        c_iv = 0, c_ir, c_ov, c_or = 0, c_busy;
   logic [31:0] c_din = 0, c_dout;
   logic [4:0]  c_sh = 0;
   logic [1:0]  c_op = 0;

   always #5 clk = ~clk;

   shift_seq #(.WIDTH(8), .STEP(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .din(a_din),
      .shamt(a_sh), .op(a_op), .out_valid(a_ov), .out_ready(a_or), .dout(a_dout), .busy(a_busy));
   shift_seq #(.WIDTH(8), .STEP(4)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .din(b_din),
      .shamt(b_sh), .op(b_op), .out_valid(b_ov), .out_ready(b_or), .dout(b_dout), .busy(b_busy));
   shift_seq #(.WIDTH(32), .STEP(8)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .din(c_din),
      .shamt(c_sh), .op(c_op), .out_valid(c_ov), .out_ready(c_or), .dout(c_dout), .busy(c_busy));

   function automatic logic ov(input int s);
      return (s == 0) ? a_ov : (s == 1) ? b_ov : c_ov;
   endfunction

   function automatic logic ir(input int s);
      return (s == 0) ? a_ir : (s == 1) ? b_ir : c_ir;
   endfunction

   function automatic logic [31:0] dq(input int s);
      return (s == 0) ? {24'h0, a_dout} : (s == 1) ? {24'h0, b_dout} : c_dout;
   endfunction

   // handshake one request and count cycles (handshake edge = 1) until out_valid
   task automatic start(input int s, input logic [31:0] d, input int sh, input logic [1:0] o,
                        output int lat);
      if (s == 0) begin a_din = d[7:0]; a_sh = 3'(sh); a_op = o; a_iv = 1; end
      else if (s == 1) begin b_din = d[7:0]; b_sh = 3'(sh); b_op = o; b_iv = 1; end
      else begin c_din = d; c_sh = 5'(sh); c_op = o; c_iv = 1; end
      @(posedge clk); #1;
      a_iv = 0; b_iv = 0; c_iv = 0;
      lat = 1;
      while (!ov(s) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out(input int s);
      if (s == 0) a_or = 1; else if (s == 1) b_or = 1; else c_or = 1;
      @(posedge clk); #1;
      a_or = 0; b_or = 0; c_or = 0;
   endtask

   task automatic test_reset;
      logic [3:0] got;
      #12;
      got = {a_ir, a_ov, a_busy, a_dout == 8'h00};
      n_assert++;
      if (got !== 4'b1001) begin $display("FAIL por {ir,ov,busy,dout0}: got %b want 1001", got); n_fail++; end
      rst_n = 1;
      @(posedge clk); #1;
      a_din = 8'hFF; a_sh = 3'd7; a_op = 2'b00; a_iv = 1;
      @(posedge clk); #1;
      a_iv = 0;
      repeat (3) @(posedge clk);
      #1;
      n_assert++;
      if (a_busy !== 1'b1) begin $display("FAIL midshift busy: got %b want 1", a_busy); n_fail++; end
      rst_n = 0;
      #1;
      got = {a_ir, a_ov, a_busy, a_dout == 8'h00};
      n_assert++;
      if (got !== 4'b1001) begin $display("FAIL async_reset {ir,ov,busy,dout0}: got %b want 1001 (dout %h)", got, a_dout); n_fail++; end
      @(negedge clk);
      rst_n = 1;
      repeat (8) begin
         @(posedge clk); #1;
         n_assert++;
         if ({a_ir, a_ov, a_busy} !== 3'b100) begin
            $display("FAIL post_reset_idle {ir,ov,busy}: got %b want 100", {a_ir, a_ov, a_busy}); n_fail++;
         end
      end
   endtask

   task automatic test_modes;
      logic [7:0] exp [4] = '{8'h16, 8'hF6, 8'hA0, 8'h96};
      int lat;
      for (int i = 0; i < 4; i++) begin
         start(0, 32'hB4, 3, 2'(i), lat);
         n_assert += 2;
         if (a_dout !== exp[i]) begin $display("FAIL mode%0d dout: got %h want %h", i, a_dout, exp[i]); n_fail++; end
         if (lat !== 4) begin $display("FAIL mode%0d latency: got %0d want 4", i, lat); n_fail++; end
         release_out(0);
         n_assert++;
         if ({a_ov, a_ir} !== 2'b01) begin $display("FAIL mode%0d release {ov,ir}: got %b want 01", i, {a_ov, a_ir}); n_fail++; end
      end
   endtask

   task automatic test_zero_and_max;
      int lat;
      start(0, 32'h81, 0, 2'b01, lat);
      n_assert += 2;
      if (a_dout !== 8'h81) begin $display("FAIL zero dout: got %h want 81", a_dout); n_fail++; end
      if (lat !== 1) begin $display("FAIL zero latency: got %0d want 1", lat); n_fail++; end
      release_out(0);
      start(0, 32'h80, 7, 2'b01, lat);
      n_assert += 2;
      if (a_dout !== 8'hFF) begin $display("FAIL max_sra dout: got %h want ff", a_dout); n_fail++; end
      if (lat !== 8) begin $display("FAIL max_sra latency: got %0d want 8", lat); n_fail++; end
      release_out(0);
   endtask

   task automatic test_multi_step;
      logic [31:0] din [3] = '{32'h80, 32'h80, 32'h01};
      int          sh  [3] = '{7, 7, 5};
      logic [1:0]  op  [3] = '{2'b01, 2'b00, 2'b10};
      logic [7:0]  exp [3] = '{8'hFF, 8'h01, 8'h20};
      int lat;
      for (int i = 0; i < 3; i++) begin
         start(1, din[i], sh[i], op[i], lat);
         n_assert += 2;
         if (b_dout !== exp[i]) begin $display("FAIL step4_%0d dout: got %h want %h", i, b_dout, exp[i]); n_fail++; end
         if (lat !== 3) begin $display("FAIL step4_%0d latency: got %0d want 3", i, lat); n_fail++; end
         release_out(1);
      end
   endtask

   task automatic test_wide;
      int lat;
      start(2, 32'h8000_0001, 31, 2'b11, lat);
      n_assert += 2;
      if (c_dout !== 32'h0000_0003) begin $display("FAIL wide_ror dout: got %h want 00000003", c_dout); n_fail++; end
      if (lat !== 5) begin $display("FAIL wide_ror latency: got %0d want 5", lat); n_fail++; end
      release_out(2);
      start(2, 32'h8765_4321, 12, 2'b01, lat);
      n_assert += 2;
      if (dq(2) !== 32'hFFF8_7654) begin $display("FAIL wide_sra dout: got %h want fff87654", c_dout); n_fail++; end
      if (lat !== 3) begin $display("FAIL wide_sra latency: got %0d want 3", lat); n_fail++; end
      release_out(2);
   endtask

   task automatic test_backpressure;
      int lat;
      start(0, 32'h5A, 1, 2'b10, lat);
      n_assert++;
      if (lat !== 2) begin $display("FAIL bp latency: got %0d want 2", lat); n_fail++; end
      a_din = 8'h0F; a_sh = 3'd2; a_op = 2'b00; a_iv = 1;
      repeat (10) begin
         n_assert++;
         if ({a_ov, ir(0), a_dout} !== {2'b10, 8'hB4}) begin
            $display("FAIL bp_hold {ov,ir,dout}: got %b %b %h want 1 0 b4", a_ov, a_ir, a_dout); n_fail++;
         end
         @(posedge clk); #1;
      end
      a_or = 1;
      @(posedge clk); #1;
      a_or = 0;
      n_assert++;
      if ({a_ov, a_ir} !== 2'b01) begin $display("FAIL bp_release {ov,ir}: got %b want 01", {a_ov, a_ir}); n_fail++; end
      @(posedge clk); #1;
      a_iv = 0;
      n_assert++;
      if ({a_busy, a_ir, a_dout} !== {2'b10, 8'h0F}) begin
         $display("FAIL bp_accept {busy,ir,dout}: got %b %b %h want 1 0 0f", a_busy, a_ir, a_dout); n_fail++;
      end
      lat = 1;
      while (!ov(0) && lat < 100) begin @(posedge clk); #1; lat++; end
      n_assert += 2;
      if (a_dout !== 8'h03) begin $display("FAIL bp_second dout: got %h want 03", a_dout); n_fail++; end
      if (lat !== 3) begin $display("FAIL bp_second latency: got %0d want 3", lat); n_fail++; end
      release_out(0);
   endtask

   task automatic test_back_to_back;
      int lat;
      for (int i = 1; i < 8; i++) begin
         start(0, 32'h01, i, 2'b10, lat);
         n_assert++;
         if (dq(0) !== (32'h1 << i) || lat !== i + 1) begin
            $display("FAIL b2b_sll%0d dout/lat: got %h/%0d want %h/%0d", i, a_dout, lat, 32'h1 << i, i + 1); n_fail++;
         end
         release_out(0);
      end
   endtask

   initial begin
      test_reset;
      test_modes;
      test_zero_and_max;
      test_multi_step;
      test_wide;
      test_backpressure;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
